// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES S-box tables, widths and table index helper
package des_pkg;

    localparam int DES_W_IN  = 48;
    localparam int DES_W_OUT = 32;

    // S1..S8, row-major: entry [row*16 + col]
    localparam logic [3:0] SBOX_TABLE [8][64] = '{
        '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7,
          4'h0, 4'hF, 4'h7, 4'h4, 4'hE, 4'h2, 4'hD, 4'h1, 4'hA, 4'h6, 4'hC, 4'hB, 4'h9, 4'h5, 4'h3, 4'h8,
          4'h4, 4'h1, 4'hE, 4'h8, 4'hD, 4'h6, 4'h2, 4'hB, 4'hF, 4'hC, 4'h9, 4'h7, 4'h3, 4'hA, 4'h5, 4'h0,
          4'hF, 4'hC, 4'h8, 4'h2, 4'h4, 4'h9, 4'h1, 4'h7, 4'h5, 4'hB, 4'h3, 4'hE, 4'hA, 4'h0, 4'h6, 4'hD},
        '{4'hF, 4'h1, 4'h8, 4'hE, 4'h6, 4'hB, 4'h3, 4'h4, 4'h9, 4'h7, 4'h2, 4'hD, 4'hC, 4'h0, 4'h5, 4'hA,
          4'h3, 4'hD, 4'h4, 4'h7, 4'hF, 4'h2, 4'h8, 4'hE, 4'hC, 4'h0, 4'h1, 4'hA, 4'h6, 4'h9, 4'hB, 4'h5,
          4'h0, 4'hE, 4'h7, 4'hB, 4'hA, 4'h4, 4'hD, 4'h1, 4'h5, 4'h8, 4'hC, 4'h6, 4'h9, 4'h3, 4'h2, 4'hF,
          4'hD, 4'h8, 4'hA, 4'h1, 4'h3, 4'hF, 4'h4, 4'h2, 4'hB, 4'h6, 4'h7, 4'hC, 4'h0, 4'h5, 4'hE, 4'h9},
        '{4'hA, 4'h0, 4'h9, 4'hE, 4'h6, 4'h3, 4'hF, 4'h5, 4'h1, 4'hD, 4'hC, 4'h7, 4'hB, 4'h4, 4'h2, 4'h8,
          4'hD, 4'h7, 4'h0, 4'h9, 4'h3, 4'h4, 4'h6, 4'hA, 4'h2, 4'h8, 4'h5, 4'hE, 4'hC, 4'hB, 4'hF, 4'h1,
          4'hD, 4'h6, 4'h4, 4'h9, 4'h8, 4'hF, 4'h3, 4'h0, 4'hB, 4'h1, 4'h2, 4'hC, 4'h5, 4'hA, 4'hE, 4'h7,
          4'h1, 4'hA, 4'hD, 4'h0, 4'h6, 4'h9, 4'h8, 4'h7, 4'h4, 4'hF, 4'hE, 4'h3, 4'hB, 4'h5, 4'h2, 4'hC},
        '{4'h7, 4'hD, 4'hE, 4'h3, 4'h0, 4'h6, 4'h9, 4'hA, 4'h1, 4'h2, 4'h8, 4'h5, 4'hB, 4'hC, 4'h4, 4'hF,
          4'hD, 4'h8, 4'hB, 4'h5, 4'h6, 4'hF, 4'h0, 4'h3, 4'h4, 4'h7, 4'h2, 4'hC, 4'h1, 4'hA, 4'hE, 4'h9,
          4'hA, 4'h6, 4'h9, 4'h0, 4'hC, 4'hB, 4'h7, 4'hD, 4'hF, 4'h1, 4'h3, 4'hE, 4'h5, 4'h2, 4'h8, 4'h4,
          4'h3, 4'hF, 4'h0, 4'h6, 4'hA, 4'h1, 4'hD, 4'h8, 4'h9, 4'h4, 4'h5, 4'hB, 4'hC, 4'h7, 4'h2, 4'hE},
        '{4'h2, 4'hC, 4'h4, 4'h1, 4'h7, 4'hA, 4'hB, 4'h6, 4'h8, 4'h5, 4'h3, 4'hF, 4'hD, 4'h0, 4'hE, 4'h9,
          4'hE, 4'hB, 4'h2, 4'hC, 4'h4, 4'h7, 4'hD, 4'h1, 4'h5, 4'h0, 4'hF, 4'hA, 4'h3, 4'h9, 4'h8, 4'h6,
          4'h4, 4'h2, 4'h1, 4'hB, 4'hA, 4'hD, 4'h7, 4'h8, 4'hF, 4'h9, 4'hC, 4'h5, 4'h6, 4'h3, 4'h0, 4'hE,
          4'hB, 4'h8, 4'hC, 4'h7, 4'h1, 4'hE, 4'h2, 4'hD, 4'h6, 4'hF, 4'h0, 4'h9, 4'hA, 4'h4, 4'h5, 4'h3},
        '{4'hC, 4'h1, 4'hA, 4'hF, 4'h9, 4'h2, 4'h6, 4'h8, 4'h0, 4'hD, 4'h3, 4'h4, 4'hE, 4'h7, 4'h5, 4'hB,
          4'hA, 4'hF, 4'h4, 4'h2, 4'h7, 4'hC, 4'h9, 4'h5, 4'h6, 4'h1, 4'hD, 4'hE, 4'h0, 4'hB, 4'h3, 4'h8,
          4'h9, 4'hE, 4'hF, 4'h5, 4'h2, 4'h8, 4'hC, 4'h3, 4'h7, 4'h0, 4'h4, 4'hA, 4'h1, 4'hD, 4'hB, 4'h6,
          4'h4, 4'h3, 4'h2, 4'hC, 4'h9, 4'h5, 4'hF, 4'hA, 4'hB, 4'hE, 4'h1, 4'h7, 4'h6, 4'h0, 4'h8, 4'hD},
        '{4'h4, 4'hB, 4'h2, 4'hE, 4'hF, 4'h0, 4'h8, 4'hD, 4'h3, 4'hC, 4'h9, 4'h7, 4'h5, 4'hA, 4'h6, 4'h1,
          4'hD, 4'h0, 4'hB, 4'h7, 4'h4, 4'h9, 4'h1, 4'hA, 4'hE, 4'h3, 4'h5, 4'hC, 4'h2, 4'hF, 4'h8, 4'h6,
          4'h1, 4'h4, 4'hB, 4'hD, 4'hC, 4'h3, 4'h7, 4'hE, 4'hA, 4'hF, 4'h6, 4'h8, 4'h0, 4'h5, 4'h9, 4'h2,
          4'h6, 4'hB, 4'hD, 4'h8, 4'h1, 4'h4, 4'hA, 4'h7, 4'h9, 4'h5, 4'h0, 4'hF, 4'hE, 4'h2, 4'h3, 4'hC},
        '{4'hD, 4'h2, 4'h8, 4'h4, 4'h6, 4'hF, 4'hB, 4'h1, 4'hA, 4'h9, 4'h3, 4'hE, 4'h5, 4'h0, 4'hC, 4'h7,
          4'h1, 4'hF, 4'hD, 4'h8, 4'hA, 4'h3, 4'h7, 4'h4, 4'hC, 4'h5, 4'h6, 4'hB, 4'h0, 4'hE, 4'h9, 4'h2,
          4'h7, 4'hB, 4'h4, 4'h1, 4'h9, 4'hC, 4'hE, 4'h2, 4'h0, 4'h6, 4'hA, 4'hD, 4'hF, 4'h3, 4'h5, 4'h8,
          4'h2, 4'h1, 4'hE, 4'h7, 4'h4, 4'hA, 4'h8, 4'hD, 4'hF, 4'hC, 4'h9, 4'h0, 4'h3, 4'h5, 4'h6, 4'hB}
    };

    function automatic logic [5:0] sbox_idx(input logic [1:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// rtl/des_sbox_lut.sv - single combinational S-box lookup, box chosen by sel
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [5:0] din,
    output logic [3:0] dout
);

    // outer bits pick the row, inner four bits the column
    assign dout = SBOX_TABLE[sel][sbox_idx({din[5], din[0]}, din[4:1])];

endmodule

// File: rtl/des_sbox_pipe.sv
// rtl/des_sbox_pipe.sv - pipelined DES substitution layer with valid/ready flow control
module des_sbox_pipe
    import des_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DES_W_IN*LANES-1:0]     in_data,
    input  logic                          in_mode,
    input  logic [2:0]                    in_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DES_W_OUT*LANES-1:0]    out_data,
    output logic                          busy
);

    logic                          lut_valid;
    logic [DES_W_IN*LANES-1:0]     lut_din;
    logic                          lut_mode;
    logic [2:0]                    lut_sel;
    logic [DES_W_OUT*LANES-1:0]    lut_dout;
    logic                          out_adv;
    logic                          front_busy;

    assign out_adv = !out_valid || out_ready;

    generate
        if (STAGES >= 2) begin : g_in_reg
            logic                      s0_valid;
            logic [DES_W_IN*LANES-1:0] s0_data;
            logic                      s0_mode;
            logic [2:0]                s0_sel;
            logic                      s0_adv;

            assign s0_adv = !s0_valid || out_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_valid <= 1'b0;
                    s0_data  <= '0;
                    s0_mode  <= 1'b0;
                    s0_sel   <= 3'd0;
                end else if (s0_adv) begin
                    s0_valid <= in_valid;
                    if (in_valid) begin
                        s0_data <= in_data;
                        s0_mode <= in_mode;
                        s0_sel  <= in_sel;
                    end
                end
            end

            assign in_ready   = s0_adv;
            assign lut_valid  = s0_valid;
            assign lut_din    = s0_data;
            assign lut_mode   = s0_mode;
            assign lut_sel    = s0_sel;
            assign front_busy = s0_valid;
        end else begin : g_no_in_reg
            assign in_ready   = out_adv;
            assign lut_valid  = in_valid;
            assign lut_din    = in_data;
            assign lut_mode   = in_mode;
            assign lut_sel    = in_sel;
            assign front_busy = 1'b0;
        end
    endgenerate

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        for (genvar j = 0; j < 8; j++) begin : g_grp
            logic [2:0] box;

            // debug broadcast reuses one box for every group
            assign box = lut_mode ? lut_sel : 3'(j);

            des_sbox_lut u_lut (
                .sel  (box),
                .din  (lut_din[DES_W_IN*k + DES_W_IN-1 - 6*j -: 6]),
                .dout (lut_dout[DES_W_OUT*k + DES_W_OUT-1 - 4*j -: 4])
            );
        end
    end

    // output data only reloads on a real beat so an idle pipe keeps the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (out_adv) begin
            out_valid <= lut_valid;
            if (lut_valid) begin
                out_data <= lut_dout;
            end
        end
    end

    assign busy = out_valid || front_busy;

endmodule

// File: tb/tb_des_sbox_pipe.sv
// tb/tb_des_sbox_pipe.sv - directed and streaming checks of des_sbox_pipe
module tb_des_sbox_pipe;

    localparam int STAGES = 2;

    localparam logic [63:0] REF_ROWS [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [47:0] in_data;
    logic [2:0]  in_sel;
    logic [31:0] out_data;

    logic        in_valid2, in_ready2, in_mode2, out_valid2, out_ready2, busy2;
    logic [95:0] in_data2;
    logic [2:0]  in_sel2;
    logic [63:0] out_data2;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    des_sbox_pipe #(.LANES(1), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    des_sbox_pipe #(.LANES(2), .STAGES(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .in_mode(in_mode2), .in_sel(in_sel2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2)
    );

    function automatic logic [31:0] ref_word(input logic [47:0] d, input logic m, input logic [2:0] s);
        logic [31:0] w;
        logic [5:0]  g;
        logic [63:0] r;
        int          b;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            g = d[47-6*j -: 6];
            b = m ? int'(s) : j;
            r = REF_ROWS[b*4 + int'({g[5], g[0]})];
            w[31-4*j -: 4] = r[63-4*int'(g[4:1]) -: 4];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [47:0] d, input logic m,
                          input logic [2:0] s, input logic [31:0] exp);
        int cyc;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_sel    = s;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        in_mode  = ~m;
        in_sel   = ~s;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(STAGES));
        check(tag, 64'(out_data), 64'(exp));
        tick();
    endtask

    task automatic stream(input int n_beats, input bit rand_mode, input int max_cycles,
                          output int cycles, output int n_out);
        int          sent;
        bit          held;
        bit          acc;
        logic [31:0] held_data;
        sent   = 0;
        held   = 1'b0;
        cycles = 0;
        n_out  = 0;
        held_data = '0;
        in_valid = 1'b0;
        while ((sent < n_beats || exp_q.size() > 0) && cycles < max_cycles) begin
            if (sent < n_beats && !in_valid) begin
                if (!rand_mode || $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = {16'($urandom), $urandom};
                    in_mode  = 1'($urandom_range(0, 1));
                    in_sel   = 3'($urandom_range(0, 7));
                end
            end
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (held) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_data", 64'(out_data), 64'(held_data));
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) begin
                n_out++;
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) check("beat_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(ref_word(in_data, in_mode, in_sel));
                sent++;
            end
            tick();
            cycles++;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, nout, n;
        rst_n = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_sel = 3'd0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; in_mode2 = 1'b0; in_sel2 = 3'd0; out_ready2 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data2", out_data2, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_in_ready2", 64'(in_ready2), 64'(1));
        tick();

        single("t1_zero", 48'h0, 1'b0, 3'd5, 32'hEFA72C4D);
        tick();
        tick();
        check("t1_idle_valid", 64'(out_valid), 64'(0));
        check("t1_idle_hold", 64'(out_data), 64'(32'hEFA72C4D));
        check("t1_idle_busy", 64'(busy), 64'(0));
        single("t2_ones", 48'hFFFF_FFFF_FFFF, 1'b0, 3'd2, 32'hD9CE3DCB);
        single("t3_sel3", 48'h0, 1'b1, 3'd3, 32'h77777777);
        single("t3_sel0", 48'h0, 1'b1, 3'd0, 32'hEEEEEEEE);
        single("t3_sel7_ones", 48'hFFFF_FFFF_FFFF, 1'b1, 3'd7, 32'hBBBBBBBB);

        stream(100, 1'b1, 3000, cyc, nout);
        check("t4_rand_nout", 64'(nout), 64'(100));
        check("t4_rand_drained", 64'(exp_q.size()), 64'(0));
        check("t4_rand_idle", 64'(busy), 64'(0));
        stream(30, 1'b0, 200, cyc, nout);
        check("t4_thru_cycles", 64'(cyc), 64'(30 + STAGES));
        check("t4_thru_nout", 64'(nout), 64'(30));

        in_valid2  = 1'b1;
        in_data2   = {48'hFFFF_FFFF_FFFF, 48'h0};
        in_mode2   = 1'b0;
        in_sel2    = 3'd4;
        out_ready2 = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 64'(in_ready2), 64'(1));
        tick();
        check("t5_valid", 64'(out_valid2), 64'(1));
        check("t5_des", out_data2, 64'hD9CE3DCB_EFA72C4D);
        in_mode2 = 1'b1;
        in_sel2  = 3'd7;
        tick();
        in_valid2 = 1'b0;
        check("t5_bcast", out_data2, 64'hBBBBBBBB_DDDDDDDD);
        tick();
        check("t5_drained", 64'(out_valid2), 64'(0));

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h0123_4567_89AB;
        in_mode   = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (!in_ready) break;
            tick();
            n++;
        end
        check("t6_fill_beats", 64'(n), 64'(STAGES));
        check("t6_full_busy", 64'(busy), 64'(1));
        out_ready = 1'b1;
        #1;
        check("t6_full_pass", 64'(in_ready), 64'(1));
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_stale", 64'(out_valid), 64'(0));
            tick();
        end
        check("t6_post_busy", 64'(busy), 64'(0));
        single("t6_after", 48'h0, 1'b1, 3'd1, 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
